muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair and serves HI/LO-class instructions issued by the CPU datapath. It accepts one operation per start handshake and computes the result over a fixed 32-iteration shift-add / restoring-divide sequence. It reports busy so the pipeline can stall later HI/LO consumers, and exposes HI/LO continuously for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_core.sv | 64 ++++++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes
// (the same encoding the ALU control decodes), FSM states and iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic [4:0] OPMULT  = 5'h01;
  localparam logic [4:0] OPMULTU = 5'h02;
  localparam logic [4:0] OPDIV   = 5'h03;
  localparam logic [4:0] OPDIVU  = 5'h04;
  localparam logic [4:0] OPMADD  = 5'h05;
  localparam logic [4:0] OPMADDU = 5'h06;
  localparam logic [4:0] OPMSUB  = 5'h07;
  localparam logic [4:0] OPMSUBU = 5'h08;
  localparam logic [4:0] OPMTHI  = 5'h09;
  localparam logic [4:0] OPMTLO  = 5'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Operations that run the 32-iteration sequence.
  function automatic logic is_calc_op(input logic [4:0] op);
    return (op == OPMULT)  || (op == OPMULTU) ||
           (op == OPDIV)   || (op == OPDIVU)  ||
           (op == OPMADD)  || (op == OPMADDU) ||
           (op == OPMSUB)  || (op == OPMSUBU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  // Operations that treat their operands as two's complement.
  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPDIV) ||
           (op == OPMADD) || (op == OPMSUB);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Single-iteration datapath shared by multiply and divide: a 64-bit shift
// register and one 33-bit adder/subtractor. Multiply is shift-add on
// unsigned magnitudes; divide is restoring division. After 32 steps the
// register holds the 64-bit product, or {remainder, quotient}.
module muldiv_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc
);

  logic [63:0] acc_reg;
  logic [31:0] b_reg;
  logic        mode_reg;
  logic [32:0] operand;
  logic [32:0] sum;
  logic [63:0] acc_next;

  // One iteration: add/subtract the latched operand and shift.
  always_comb begin
    // NOTE: every signal of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    operand  = '0;
    sum      = '0;
    acc_next = acc_reg;
    if (mode_reg) begin
      // Divide: bring in the next dividend bit and trial-subtract the divisor.
      operand = acc_reg[63:31];
      sum     = operand - {1'b0, b_reg};
      if (!sum[32]) acc_next = {sum[31:0], acc_reg[30:0], 1'b1};
      else          acc_next = {acc_reg[62:0], 1'b0};
    end else begin
      // Multiply: add the multiplicand into the upper half when the low bit is set.
      operand = {1'b0, acc_reg[63:32]};
      sum     = operand + {1'b0, b_reg};
      if (acc_reg[0]) acc_next = {sum, acc_reg[31:1]};
      else            acc_next = {1'b0, acc_reg[63:1]};
    end
  end

  // Operand latch on load, one iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      acc_reg  <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
    end else if (load) begin
      acc_reg  <= {32'd0, a_mag};
      b_reg    <= b_mag;
      mode_reg <= div_mode;
    end else if (step) begin
      acc_reg  <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair. Accepts one
// operation per start handshake, iterates 32 times, then applies sign
// correction and accumulation in a single FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic [4:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iCancel,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivZero,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  count;
  logic [4:0]  op_reg;
  logic [31:0] a_raw;
  logic        a_sign;
  logic        b_sign;
  logic        b_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_zero;

  logic        busy;
  logic        start_ok;
  logic        accept_calc;
  logic        accept_mthi;
  logic        accept_mtlo;
  logic        fix_commit;
  logic        in_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] core_acc;

  logic        op_signed;
  logic        op_div;
  logic        prod_neg;
  logic        rem_neg;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign busy        = (state != IDLE);
  // A cancel in IDLE suppresses any same-cycle request, including MTHI/MTLO.
  assign start_ok    = iStart && !busy && !iCancel;
  assign accept_calc = start_ok && is_calc_op(iOp);
  assign accept_mthi = start_ok && (iOp == OPMTHI);
  assign accept_mtlo = start_ok && (iOp == OPMTLO);
  assign fix_commit  = (state == FIX) && !iCancel;

  // Magnitudes are formed at accept so the core only ever sees unsigned values.
  assign in_signed = is_signed_op(iOp);
  assign a_mag     = (in_signed && iA[31]) ? (~iA + 32'd1) : iA;
  assign b_mag     = (in_signed && iB[31]) ? (~iB + 32'd1) : iB;

  muldiv_core u_core (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .load     (accept_calc),
    .step     (state == CALC),
    .div_mode (is_div_op(iOp)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (core_acc)
  );

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= next_state;
  end

  // FSM next-state: cancel returns to IDLE from any busy state.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept_calc) next_state = CALC;
      CALC: begin
        if (iCancel)           next_state = IDLE;
        else if (count == 5'd0) next_state = FIX;
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sign correction and HI/LO update computed for the FIX cycle.
  always_comb begin
    op_signed = is_signed_op(op_reg);
    op_div    = is_div_op(op_reg);
    prod_neg  = op_signed && (a_sign ^ b_sign);
    rem_neg   = op_signed && a_sign;
    prod_s    = prod_neg ? (~core_acc + 64'd1) : core_acc;
    quo_s     = prod_neg ? (~core_acc[31:0] + 32'd1) : core_acc[31:0];
    rem_s     = rem_neg ? (~core_acc[63:32] + 32'd1) : core_acc[63:32];
    fix_hi    = hi;
    fix_lo    = lo;
    case (op_reg)
      OPMULT, OPMULTU: {fix_hi, fix_lo} = prod_s;
      OPMADD, OPMADDU: {fix_hi, fix_lo} = {hi, lo} + prod_s;
      OPMSUB, OPMSUBU: {fix_hi, fix_lo} = {hi, lo} - prod_s;
      OPDIV, OPDIVU: begin
        if (b_zero) begin
          fix_hi = a_raw;
          fix_lo = 32'hFFFF_FFFF;
        end else begin
          fix_hi = rem_s;
          fix_lo = quo_s;
        end
      end
      default: begin
        fix_hi = hi;
        fix_lo = lo;
      end
    endcase
  end

  // Iteration counter and per-operation attributes latched at accept.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      count  <= '0;
      op_reg <= '0;
      a_raw  <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept_calc) begin
      count  <= 5'(MULDIV_ITER - 1);
      op_reg <= iOp;
      a_raw  <= iA;
      a_sign <= iA[31];
      b_sign <= iB[31];
      b_zero <= (iB == 32'd0);
    end else if ((state == CALC) && (count != 5'd0)) begin
      count  <= count - 5'd1;
    end
  end

  // Architectural HI/LO: direct moves at accept, computed results at FIX.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_commit) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else begin
      if (accept_mthi) hi <= iA;
      if (accept_mtlo) lo <= iA;
    end
  end

  // Completion pulse and divide-by-zero qualifier, one cycle after FIX.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= fix_commit;
      div_zero <= fix_commit && op_div && b_zero;
    end
  end

  assign oBusy    = busy;
  assign oDone    = done;
  assign oDivZero = div_zero;
  assign oHI      = hi;
  assign oLO      = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model predicts HI/LO and
// the divide-by-zero flag when an operation is issued; results are popped
// from a queue and compared when oDone pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        iCLK;
  logic        iRST_n;
  logic        iStart;
  logic [4:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iCancel;
  logic        oBusy;
  logic        oDone;
  logic        oDivZero;
  logic [31:0] oHI;
  logic [31:0] oLO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  int          total;
  int          bad;

  muldiv_unit dut (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .iStart   (iStart),
    .iOp      (iOp),
    .iA       (iA),
    .iB       (iB),
    .iCancel  (iCancel),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oDivZero (oDivZero),
    .oHI      (oHI),
    .oLO      (oLO)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Reference model: updates m_hi/m_lo and returns the expected outcome.
  function automatic exp_t predict(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string name);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] hl;
    int          sa;
    int          sbv;
    e.dz   = 1'b0;
    e.name = name;
    hl     = {m_hi, m_lo};
    sa     = a;
    sbv    = b;
    if (op == OPMULT || op == OPMADD || op == OPMSUB)
      p = longint'(sa) * longint'(sbv);
    else
      p = {32'd0, a} * {32'd0, b};
    case (op)
      OPMULT, OPMULTU: hl = p;
      OPMADD, OPMADDU: hl = hl + p;
      OPMSUB, OPMSUBU: hl = hl - p;
      OPDIV, OPDIVU: begin
        if (b == 32'd0) begin
          hl   = {a, 32'hFFFF_FFFF};
          e.dz = 1'b1;
        end else if (op == OPDIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hl = {32'd0, 32'h8000_0000};
        end else if (op == OPDIV) begin
          hl = {32'(sa % sbv), 32'(sa / sbv)};
        end else begin
          hl = {a % b, a / b};
        end
      end
      default: ;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
    e.hi = m_hi;
    e.lo = m_lo;
    return e;
  endfunction

  // Drive one request starting at a negedge; returns at the negedge after accept.
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scored, input string name);
    prev_hi = m_hi;
    prev_lo = m_lo;
    if (scored) sb.push_back(predict(op, a, b, name));
    iStart = 1'b1;
    iOp    = op;
    iA     = a;
    iB     = b;
    @(negedge iCLK);
    iStart = 1'b0;
    iA     = $urandom;
    iB     = $urandom;
  endtask

  // Wait (bounded) for oDone, then pop the scoreboard and compare.
  task automatic finish_op(input int start_cyc);
    int   cyc;
    bit   hold_bad;
    exp_t e;
    cyc      = start_cyc;
    hold_bad = 1'b0;
    while (oDone !== 1'b1 && cyc < 40) begin
      if (oBusy === 1'b1 && (oHI !== prev_hi || oLO !== prev_lo)) hold_bad = 1'b1;
      @(negedge iCLK);
      cyc++;
    end
    e = sb.pop_front();
    total++;
    if (oDone !== 1'b1) begin
      bad++;
      $display("FAIL %s done_timeout: got oDone=%b after %0d cycles, required 1", e.name, oDone, cyc);
    end else begin
      total++;
      if (cyc != 34) begin
        bad++;
        $display("FAIL %s latency: got %0d, required 34", e.name, cyc);
      end
      total++;
      if (oHI !== e.hi || oLO !== e.lo) begin
        bad++;
        $display("FAIL %s hilo: got %h_%h, required %h_%h", e.name, oHI, oLO, e.hi, e.lo);
      end
      total++;
      if (oDivZero !== e.dz || oBusy !== 1'b0) begin
        bad++;
        $display("FAIL %s flags: got dz=%b busy=%b, required dz=%b busy=0", e.name, oDivZero, oBusy, e.dz);
      end
      total++;
      if (hold_bad) begin
        bad++;
        $display("FAIL %s hold: HI/LO changed while busy, required %h_%h", e.name, prev_hi, prev_lo);
      end
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    @(negedge iCLK);
    issue(op, a, b, 1'b1, name);
    finish_op(1);
  endtask

  task automatic test_reset;
    iRST_n = 1'b0;
    #12;
    total++;
    if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || oDivZero !== 1'b0) begin
      bad++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b dz=%b, required all 0", oHI, oLO, oBusy, oDone, oDivZero);
    end
    @(negedge iCLK);
    iRST_n = 1'b1;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
  endtask

  task automatic test_mult;
    run_op(OPMULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    run_op(OPMULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
    run_op(OPMULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
    for (int i = 0; i < 4; i++) begin
      run_op(OPMULT,  $urandom, $urandom, "mult_rand");
      run_op(OPMULTU, $urandom, $urandom, "multu_rand");
    end
  endtask

  task automatic test_div;
    run_op(OPDIV,  32'hFFFF_FFF9, 32'h0000_0002, "div_neg7");
    run_op(OPDIVU, 32'h0000_0007, 32'h0000_0000, "divu_zero");
    run_op(OPDIV,  32'hFFFF_FFF9, 32'h0000_0000, "div_zero_neg");
    run_op(OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OPDIV,  32'h0000_0007, 32'hFFFF_FFFE, "div_negdivisor");
    for (int i = 0; i < 4; i++) begin
      run_op(OPDIV,  $urandom, $urandom_range(1, 1000), "div_rand");
      run_op(OPDIVU, $urandom, $urandom, "divu_rand");
    end
  endtask

  task automatic test_mt;
    @(negedge iCLK);
    issue(OPMTLO, 32'h1234_5678, 32'h0, 1'b0, "mtlo");
    m_lo = 32'h1234_5678;
    total++;
    if (oLO !== 32'h1234_5678 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: got lo=%h busy=%b done=%b, required lo=12345678 busy=0 done=0", oLO, oBusy, oDone);
    end
    issue(OPMTHI, 32'hCAFE_F00D, 32'h0, 1'b0, "mthi");
    m_hi = 32'hCAFE_F00D;
    total++;
    if (oHI !== 32'hCAFE_F00D || oLO !== 32'h1234_5678 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b, required cafef00d 12345678 0", oHI, oLO, oBusy);
    end
  endtask

  task automatic test_madd;
    @(negedge iCLK);
    issue(OPMTHI, 32'h0, 32'h0, 1'b0, "mthi0");
    m_hi = 32'h0;
    issue(OPMTLO, 32'hFFFF_FFFF, 32'h0, 1'b0, "mtlo_ones");
    m_lo = 32'hFFFF_FFFF;
    run_op(OPMADDU, 32'd1, 32'd1, "maddu_carry");
    run_op(OPMSUB,  32'd1, 32'd1, "msub_borrow");
    run_op(OPMADD,  32'hFFFF_FFFD, 32'd5, "madd_neg");
    run_op(OPMSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu_big");
  endtask

  task automatic test_busy_ignore;
    bit extra;
    @(negedge iCLK);
    issue(OPMULT, 32'd1000, 32'd3, 1'b1, "busy_first");
    repeat (4) @(negedge iCLK);
    iStart = 1'b1;
    iOp    = OPDIVU;
    iA     = 32'd100;
    iB     = 32'd7;
    @(negedge iCLK);
    iStart = 1'b0;
    finish_op(6);
    extra = 1'b0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone === 1'b1 || oBusy === 1'b1) extra = 1'b1;
    end
    total++;
    if (extra || oHI !== m_hi || oLO !== m_lo) begin
      bad++;
      $display("FAIL busy_ignore: extra activity=%b hi=%h lo=%h, required none and %h %h", extra, oHI, oLO, m_hi, m_lo);
    end
  endtask

  task automatic test_cancel;
    bit seen;
    @(negedge iCLK);
    issue(OPMULT, 32'h1111_1111, 32'h2222_2222, 1'b0, "cancel_calc");
    repeat (9) @(negedge iCLK);
    iCancel = 1'b1;
    @(negedge iCLK);
    iCancel = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (oDone === 1'b1) seen = 1'b1;
      @(negedge iCLK);
    end
    total++;
    if (seen || oBusy !== 1'b0 || oHI !== m_hi || oLO !== m_lo) begin
      bad++;
      $display("FAIL cancel_calc: done_seen=%b busy=%b hi=%h lo=%h, required 0 0 %h %h", seen, oBusy, oHI, oLO, m_hi, m_lo);
    end
    // Cancel landing exactly on the FIX cycle.
    issue(OPMULTU, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, "cancel_fix");
    repeat (32) @(negedge iCLK);
    total++;
    if (oBusy !== 1'b1) begin
      bad++;
      $display("FAIL cancel_fix_busy: got busy=%b, required 1", oBusy);
    end
    iCancel = 1'b1;
    @(negedge iCLK);
    iCancel = 1'b0;
    total++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oHI !== m_hi || oLO !== m_lo) begin
      bad++;
      $display("FAIL cancel_fix: done=%b busy=%b hi=%h lo=%h, required 0 0 %h %h", oDone, oBusy, oHI, oLO, m_hi, m_lo);
    end
    // Cancel in IDLE blocks a same-cycle start.
    iCancel = 1'b1;
    issue(OPMTLO, 32'hDEAD_0000, 32'h0, 1'b0, "cancel_idle_mt");
    iStart  = 1'b1;
    iOp     = OPMULT;
    @(negedge iCLK);
    iStart  = 1'b0;
    iCancel = 1'b0;
    total++;
    if (oBusy !== 1'b0 || oLO !== m_lo) begin
      bad++;
      $display("FAIL cancel_idle: busy=%b lo=%h, required 0 %h", oBusy, oLO, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge iCLK);
    issue(OPMULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, "b2b_first");
    finish_op(1);
    issue(OPDIV, 32'hFFFF_FF9C, 32'd7, 1'b1, "b2b_second");
    finish_op(1);
    issue(OPMADD, 32'd2, 32'hFFFF_FFFF, 1'b1, "b2b_third");
    finish_op(1);
  endtask

  task automatic test_reset_mid;
    @(negedge iCLK);
    issue(OPMTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, "pre_rst_hi");
    m_hi = 32'hDEAD_BEEF;
    issue(OPMULT, 32'd12345, 32'd678, 1'b0, "rst_mid");
    repeat (9) @(negedge iCLK);
    #2;
    iRST_n = 1'b0;
    #1;
    total++;
    if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || oDivZero !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b dz=%b, required all 0", oHI, oLO, oBusy, oDone, oDivZero);
    end
    @(negedge iCLK);
    iRST_n = 1'b1;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    run_op(OPMULTU, 32'd9, 32'd9, "after_reset");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    iStart  = 1'b0;
    iOp     = '0;
    iA      = '0;
    iB      = '0;
    iCancel = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    prev_hi = '0;
    prev_lo = '0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_madd();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
